// File: rtl/dpll_bitsync_ctrl_if.sv
// Bit-sync loop signal bundle: quadrature pulse trains and sampled data in,
// recovered bit clock, correction strobes and lock flag out.
// master = pulse generator / data source side, slave = dpll_bitsync_ctrl.
interface dpll_bitsync_ctrl_if;
  logic clk_d1;
  logic clk_d2;
  logic din;
  logic bit_clk;
  logic corr_add;
  logic corr_ded;
  logic locked;

  modport master (
    output clk_d1, clk_d2, din,
    input  bit_clk, corr_add, corr_ded, locked
  );

  modport slave (
    input  clk_d1, clk_d2, din,
    output bit_clk, corr_add, corr_ded, locked
  );
endinterface

// File: rtl/dpll_bitsync_ctrl.sv
// Digital PLL bit synchroniser, consumer end of the dual-phase clock generator.
// Data transitions are classified lead/lag against the local divider phase;
// a lag inserts the clk_d2 pulse, a lead deducts the next clk_d1 pulse ahead
// of the modulo-DIV divider that produces bit_clk.
// Optional lock detector enabled by defining DPLL_LOCK_DET_EN; without it
// locked is tied low and LOCK_WIN / LOCK_THR have no effect.
//
// Pending-correction FSM:
//   state   | meaning
//   ST_IDLE | no correction pending; clk_d1 forwarded, clk_d2 dropped
//   ST_ADD  | local clock late; next clk_d2 is forwarded as an extra pulse
//   ST_DED  | local clock early; next clk_d1 is swallowed
//   ST_BOTH | conflicting edges seen before either was applied; cancel both
module dpll_bitsync_ctrl #(
  parameter int DIV      = 8,
  parameter int LOCK_WIN = 32,
  parameter int LOCK_THR = 8
) (
  input  logic              clk32,
  input  logic              rst_n,
  dpll_bitsync_ctrl_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DED  = 2'd2,
    ST_BOTH = 2'd3
  } pend_state_e;

  pend_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          din_q;
  logic          din_edge;
  logic          late;
  logic          fwd;
  logic          add_d, ded_d;
  logic          bit_clk_q, corr_add_q, corr_ded_q;

  assign din_edge = bus.din ^ din_q;
  // An edge in the first half of the bit means the local clock is lagging.
  assign late     = (cnt_q < CNT_HALF);

  // Pending-correction state register.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next pending state, pulse gating and divider next value.
  // A flag consumed by its pulse is cleared even if a same-type edge arrives
  // in that cycle: that edge was already covered by the flag being applied.
  always_comb begin
    state_d = state_q;
    fwd     = 1'b0;
    add_d   = 1'b0;
    ded_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fwd = bus.clk_d1;
        if (din_edge) state_d = late ? ST_ADD : ST_DED;
      end
      ST_ADD: begin
        fwd   = bus.clk_d1 | bus.clk_d2;
        add_d = bus.clk_d2;
        if (!bus.clk_d2 && din_edge && !late) state_d = ST_BOTH;
        else if (!bus.clk_d2)                 state_d = ST_ADD;
        else if (din_edge && !late)           state_d = ST_DED;
        else                                  state_d = ST_IDLE;
      end
      ST_DED: begin
        fwd   = 1'b0;
        ded_d = bus.clk_d1;
        if (!bus.clk_d1 && din_edge && late) state_d = ST_BOTH;
        else if (!bus.clk_d1)                state_d = ST_DED;
        else if (din_edge && late)           state_d = ST_ADD;
        else                                 state_d = ST_IDLE;
      end
      ST_BOTH: begin
        fwd     = bus.clk_d1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fwd) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    else     cnt_d = cnt_q;
  end

  // Edge-detect register, divider and registered outputs.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      din_q      <= 1'b0;
      cnt_q      <= '0;
      bit_clk_q  <= 1'b0;
      corr_add_q <= 1'b0;
      corr_ded_q <= 1'b0;
    end else begin
      din_q      <= bus.din;
      cnt_q      <= cnt_d;
      bit_clk_q  <= (cnt_d >= CNT_HALF);
      corr_add_q <= add_d;
      corr_ded_q <= ded_d;
    end
  end

  assign bus.bit_clk  = bit_clk_q;
  assign bus.corr_add = corr_add_q;
  assign bus.corr_ded = corr_ded_q;

`ifdef DPLL_LOCK_DET_EN
  localparam int WW  = $clog2(LOCK_WIN + 1);
  localparam int CCW = $clog2(LOCK_THR + 2);
  localparam logic [WW-1:0]  WIN_LAST = WW'(LOCK_WIN - 1);
  localparam logic [CCW-1:0] CORR_THR = CCW'(LOCK_THR);
  localparam logic [CCW-1:0] CORR_SAT = CCW'(LOCK_THR + 1);

  logic [WW-1:0]  win_cnt_q;
  logic [CCW-1:0] corr_cnt_q;
  logic           bit_clk_prev_q;
  logic           locked_q;
  logic           bit_rise;
  logic           corr_evt;

  assign bit_rise = bit_clk_q & ~bit_clk_prev_q;
  assign corr_evt = corr_add_q | corr_ded_q;

  // Windowed correction count; the verdict only moves at window ends.
  // The corrector saturates one above the threshold, enough to say "too many".
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q      <= '0;
      corr_cnt_q     <= '0;
      bit_clk_prev_q <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      bit_clk_prev_q <= bit_clk_q;
      if (bit_rise && (win_cnt_q == WIN_LAST)) begin
        locked_q   <= (corr_cnt_q <= CORR_THR);
        win_cnt_q  <= '0;
        corr_cnt_q <= '0;
      end else begin
        if (bit_rise) win_cnt_q <= win_cnt_q + 1'b1;
        if (corr_evt && (corr_cnt_q != CORR_SAT)) corr_cnt_q <= corr_cnt_q + 1'b1;
      end
    end
  end

  assign bus.locked = locked_q;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_WIN, LOCK_THR};
  assign bus.locked      = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_bitsync_ctrl.sv
`timescale 1ns/1ps
module tb_dpll_bitsync_ctrl;
  localparam int DIV      = 8;
  localparam int LOCK_WIN = 32;
  localparam int LOCK_THR = 8;

  logic clk32 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk32 = ~clk32;

  dpll_bitsync_ctrl_if bus();

  dpll_bitsync_ctrl #(.DIV(DIV), .LOCK_WIN(LOCK_WIN), .LOCK_THR(LOCK_THR)) dut (
    .clk32 (clk32),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ph     = 0;
  bit run    = 1'b0;
  logic din_v = 1'b0;

  // reference model: total forwarded pulses, pending corrections, lock window
  bit m_din_q, m_add, m_ded;
  int m_total;
  bit e_bc, e_add, e_ded, e_lock;
  bit m_locked, m_bc_prev;
  int m_win, m_corr;

  logic [3:0] act, exp_v;
  logic prev_bc;
  int rises[$];
  int falls[$];
  int n_add, n_ded;

  task automatic model_reset();
    m_din_q = 0; m_add = 0; m_ded = 0; m_total = 0;
    e_bc = 0; e_add = 0; e_ded = 0;
    m_locked = 0; m_bc_prev = 0; m_win = 0; m_corr = 0;
  endtask

  task automatic step(input logic d);
    bit d1, d2, dedge, late, fwd, sa, sd, na, nd, strobe, rise;
    d1 = run && (ph == 0);
    d2 = run && (ph == 2);
    bus.din = d; bus.clk_d1 = d1; bus.clk_d2 = d2;
    @(posedge clk32);
    if (!rst_n) begin
      model_reset();
    end else begin
      dedge = (d != m_din_q);
      late  = (m_total % DIV) < (DIV / 2);
      if (m_add && m_ded) begin
        fwd = d1; sa = 0; sd = 0; na = 0; nd = 0;
      end else begin
        sa  = d2 && m_add;
        sd  = d1 && m_ded;
        fwd = (d1 && !m_ded) || (d2 && m_add);
        na  = (m_add && !sa) || (dedge && late && !m_add);
        nd  = (m_ded && !sd) || (dedge && !late && !m_ded);
      end
      m_add = na; m_ded = nd; m_din_q = d;
      if (fwd) m_total++;
      e_bc  = (m_total % DIV) >= (DIV / 2);
      e_add = sa; e_ded = sd;
    end
    if (run) ph = (ph + 1) % 4;
    cyc++;
    #1;
`ifdef DPLL_LOCK_DET_EN
    e_lock = m_locked;
`else
    e_lock = 1'b0;
`endif
    act   = {bus.bit_clk, bus.corr_add, bus.corr_ded, bus.locked};
    exp_v = {e_bc, e_add, e_ded, e_lock};
    if (bus.bit_clk === 1'b1 && prev_bc === 1'b0) rises.push_back(cyc);
    if (bus.bit_clk === 1'b0 && prev_bc === 1'b1) falls.push_back(cyc);
    prev_bc = bus.bit_clk;
    if (bus.corr_add === 1'b1) n_add++;
    if (bus.corr_ded === 1'b1) n_ded++;
    if (rst_n) begin
      strobe = e_add || e_ded;
      rise   = e_bc && !m_bc_prev;
      if (rise && m_win == LOCK_WIN - 1) begin
        m_locked = (m_corr <= LOCK_THR);
        m_win = 0; m_corr = 0;
      end else begin
        if (rise) m_win++;
        if (strobe && m_corr < LOCK_THR + 1) m_corr++;
      end
      m_bc_prev = e_bc;
    end
  endtask

  task automatic clear_stats();
    rises.delete(); falls.delete(); n_add = 0; n_ded = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; run = 0; din_v = 0; prev_bc = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    rst_n = 1; run = 1; ph = 0; cyc = 0;
  endtask

  task automatic test_free_run();
    int bad, hi;
    clear_stats();
    for (int i = 0; i < 200; i++) begin
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL free_run cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    checks++;
    if (rises.size() < 1 || rises[0] != 13) begin
      errors++; $display("FAIL first_rise got=%0d exp=13", rises.size() ? rises[0] : -1);
    end
    bad = 0;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 4 * DIV) bad++;
    checks++;
    if (bad != 0 || rises.size() < 5) begin
      errors++; $display("FAIL free_period bad=%0d rises=%0d exp_bad=0", bad, rises.size());
    end
    hi = -1;
    for (int i = 0; i < falls.size(); i++) if (hi < 0 && falls[i] > rises[0]) hi = falls[i] - rises[0];
    checks++;
    if (hi != 2 * DIV) begin
      errors++; $display("FAIL free_high got=%0d exp=%0d", hi, 2 * DIV);
    end
    checks++;
    if (n_add != 0 || n_ded != 0) begin
      errors++; $display("FAIL free_strobes add=%0d ded=%0d exp=0", n_add, n_ded);
    end
  endtask

  // one edge at divider phase tgt; expect one strobe and one odd period
  task automatic test_single(input string nm, input int tgt, input int exp_per,
                             input bit exp_is_add);
    bit found;
    int n_odd, odd_val;
    clear_stats();
    for (int i = 0; i < 40; i++) begin
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL %s_pre cyc=%0d got=%b exp=%b", nm, cyc, act, exp_v);
      end
    end
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_total % DIV == tgt && !m_add && !m_ded) found = 1;
      else begin
        step(din_v);
        checks++;
        if (act !== exp_v) begin
          errors++; $display("FAIL %s_align cyc=%0d got=%b exp=%b", nm, cyc, act, exp_v);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL %s_timeout got=0 exp=1", nm);
    end
    din_v = ~din_v;
    for (int i = 0; i < 120; i++) begin
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp_v);
      end
    end
    n_odd = 0; odd_val = 0;
    for (int i = 1; i < rises.size(); i++)
      if (rises[i] - rises[i-1] != 4 * DIV) begin n_odd++; odd_val = rises[i] - rises[i-1]; end
    checks++;
    if (n_odd != 1 || odd_val != exp_per) begin
      errors++; $display("FAIL %s_period n_odd=%0d got=%0d exp=%0d", nm, n_odd, odd_val, exp_per);
    end
    checks++;
    if (n_add != (exp_is_add ? 1 : 0) || n_ded != (exp_is_add ? 0 : 1)) begin
      errors++; $display("FAIL %s_strobes add=%0d ded=%0d exp_add=%0d", nm, n_add, n_ded, exp_is_add);
    end
  endtask

  task automatic test_cancel();
    bit found;
    int bad;
    clear_stats();
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_total % DIV == 3 && ph == 3 && !m_add && !m_ded) found = 1;
      else begin
        step(din_v);
        checks++;
        if (act !== exp_v) begin
          errors++; $display("FAIL cancel_align cyc=%0d got=%b exp=%b", cyc, act, exp_v);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL cancel_timeout got=0 exp=1");
    end
    for (int i = 0; i < 120; i++) begin
      if (i == 0 || i == 2) din_v = ~din_v;
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL cancel cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    bad = 0;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 4 * DIV) bad++;
    checks++;
    if (bad != 0 || n_add != 0 || n_ded != 0) begin
      errors++; $display("FAIL cancel_result bad_per=%0d add=%0d ded=%0d exp=0", bad, n_add, n_ded);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) din_v = ~din_v;
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
  endtask

  task automatic test_track();
    int off;
    off = $urandom_range(0, 33);
    for (int i = 0; i < 34 * 40; i++) begin
      if ((i + off) % 34 == 0) din_v = ~din_v;
      if (i == 34 * 30) begin n_add = 0; n_ded = 0; end
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL track cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    checks++;
    if (n_add + n_ded > 11) begin
      errors++; $display("FAIL track_steady got=%0d exp_max=11", n_add + n_ded);
    end
  endtask

`ifdef DPLL_LOCK_DET_EN
  task automatic test_lock();
    int off;
    off = $urandom_range(0, 159);
    for (int i = 0; i < 4 * LOCK_WIN * 4 * DIV + 200; i++) begin
      if ((i + off) % 160 == 0) din_v = ~din_v;
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL lock cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++; $display("FAIL lock_final got=%b exp=1", bus.locked);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit found;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if ((m_total % DIV) < DIV / 2 && ph == 3 && !m_add && !m_ded) found = 1;
      else begin
        step(din_v);
        checks++;
        if (act !== exp_v) begin
          errors++; $display("FAIL rstmid_align cyc=%0d got=%b exp=%b", cyc, act, exp_v);
        end
      end
    end
    din_v = ~din_v;
    step(din_v);
    checks++;
    if (!found || !m_add || act !== exp_v) begin
      errors++; $display("FAIL rstmid_setup found=%0d add=%0d got=%b exp=%b", found, m_add, act, exp_v);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.bit_clk, bus.corr_add, bus.corr_ded, bus.locked} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async got=%b exp=0000",
                         {bus.bit_clk, bus.corr_add, bus.corr_ded, bus.locked});
    end
    model_reset();
    run = 0; din_v = 0;
    for (int i = 0; i < 3; i++) begin
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL rstmid_hold cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    rst_n = 1; run = 1; ph = 0; cyc = 0;
    clear_stats();
    for (int i = 0; i < 60; i++) begin
      step(din_v);
      checks++;
      if (act !== exp_v) begin
        errors++; $display("FAIL rstmid_after cyc=%0d got=%b exp=%b", cyc, act, exp_v);
      end
    end
    checks++;
    if (n_add != 0 || rises.size() < 1 || rises[0] != 13) begin
      errors++; $display("FAIL rstmid_restart add=%0d first_rise=%0d exp_add=0 exp_rise=13",
                         n_add, rises.size() ? rises[0] : -1);
    end
  endtask

  initial begin
    bus.din = 0; bus.clk_d1 = 0; bus.clk_d2 = 0;
    test_reset();
    test_free_run();
    test_single("single_add", 2, 4 * DIV - 4, 1'b1);
    test_single("single_ded", 6, 4 * DIV + 4, 1'b0);
    test_cancel();
    test_random();
    test_track();
`ifdef DPLL_LOCK_DET_EN
    test_lock();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
